// File: rtl/timestamp_reader.sv
// Captures a 10 Hz timestamp into a shadow register on the settled (falling) edge of
// CLK_10HZ and serializes a requested snapshot as an optional header plus three bytes.
module timestamp_reader #(
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BYTE = 8'h54
) (
  input  logic        CLK,
  input  logic        NSYSRESET,
  input  logic        CLK_10HZ,
  input  logic [23:0] TIMESTAMP,
  input  logic        REQ,
  input  logic        BYTE_READY,
  output logic [7:0]  BYTE_OUT,
  output logic        BYTE_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic [23:0] STAMP,
  output logic        TS_UPDATE
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    B2,
    B1,
    B0,
    FIN
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        ts_sync1;
  logic        ts_sync2;
  logic        ts_prev;
  logic        ts_fall;
  logic [23:0] shadow;

  // Two flops for metastability, the third remembers the previous level for edge detection.
  always_ff @(posedge CLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      ts_sync1 <= 1'b0;
      ts_sync2 <= 1'b0;
      ts_prev  <= 1'b0;
    end else begin
      ts_sync1 <= CLK_10HZ;
      ts_sync2 <= ts_sync1;
      ts_prev  <= ts_sync2;
    end
  end

  // TIMESTAMP moves on the rising edge, so the falling edge is half a period away from any change.
  assign ts_fall   = ts_prev & ~ts_sync2;
  assign TS_UPDATE = ts_fall;

  always_ff @(posedge CLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      shadow <= 24'h000000;
    end else if (ts_fall) begin
      shadow <= TIMESTAMP;
    end
  end

  // STAMP sees the pre-load shadow when a request and a shadow load share an edge.
  always_ff @(posedge CLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      STAMP <= 24'h000000;
    end else if (state == IDLE && REQ) begin
      STAMP <= shadow;
    end
  end

  always_ff @(posedge CLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    BYTE_OUT   = 8'h00;
    BYTE_VALID = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      IDLE: begin
        if (REQ) begin
          next_state = HEADER_EN ? HDR : B2;
        end
      end
      HDR: begin
        BYTE_OUT   = HEADER_BYTE;
        BYTE_VALID = 1'b1;
        BUSY       = 1'b1;
        if (BYTE_READY) next_state = B2;
      end
      B2: begin
        BYTE_OUT   = STAMP[23:16];
        BYTE_VALID = 1'b1;
        BUSY       = 1'b1;
        if (BYTE_READY) next_state = B1;
      end
      B1: begin
        BYTE_OUT   = STAMP[15:8];
        BYTE_VALID = 1'b1;
        BUSY       = 1'b1;
        if (BYTE_READY) next_state = B0;
      end
      B0: begin
        BYTE_OUT   = STAMP[7:0];
        BYTE_VALID = 1'b1;
        BUSY       = 1'b1;
        if (BYTE_READY) next_state = FIN;
      end
      FIN: begin
        DONE       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_timestamp_reader.sv
// Scoreboard bench: a header and a headerless instance share stimulus; each has its own
// expected-byte queue filled at request time and drained by a per-cycle monitor.
module tb_timestamp_reader;

  logic        CLK = 1'b0;
  logic        NSYSRESET;
  logic        CLK_10HZ;
  logic [23:0] TIMESTAMP;
  logic        REQ;
  logic        BYTE_READY;

  logic [7:0]  bo_h, bo_n;
  logic        bv_h, bv_n, busy_h, busy_n, done_h, done_n, tsu_h, tsu_n;
  logic [23:0] stamp_h, stamp_n;

  int          errors = 0;
  int          checks = 0;

  logic [8:0]  q_h[$];
  logic [8:0]  q_n[$];
  bit          done_pend[2];
  bit          hold[2];
  logic [7:0]  hold_byte[2];
  bit          ts_window;
  logic [23:0] model_shadow;
  logic [23:0] stamp_exp;

  always #5 CLK = ~CLK;

  timestamp_reader #(.HEADER_EN(1'b1), .HEADER_BYTE(8'h54)) dut_h (
    .CLK(CLK), .NSYSRESET(NSYSRESET), .CLK_10HZ(CLK_10HZ), .TIMESTAMP(TIMESTAMP),
    .REQ(REQ), .BYTE_READY(BYTE_READY), .BYTE_OUT(bo_h), .BYTE_VALID(bv_h),
    .BUSY(busy_h), .DONE(done_h), .STAMP(stamp_h), .TS_UPDATE(tsu_h)
  );

  timestamp_reader #(.HEADER_EN(1'b0), .HEADER_BYTE(8'h54)) dut_n (
    .CLK(CLK), .NSYSRESET(NSYSRESET), .CLK_10HZ(CLK_10HZ), .TIMESTAMP(TIMESTAMP),
    .REQ(REQ), .BYTE_READY(BYTE_READY), .BYTE_OUT(bo_n), .BYTE_VALID(bv_n),
    .BUSY(busy_n), .DONE(done_n), .STAMP(stamp_n), .TS_UPDATE(tsu_n)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_idle();
    return q_h.size() == 0 && q_n.size() == 0 && !done_pend[0] && !done_pend[1];
  endfunction

  function automatic bit model_busy(input int d);
    return (d == 0) ? (q_h.size() != 0 || done_pend[0]) : (q_n.size() != 0 || done_pend[1]);
  endfunction

  // The reference transfer: optional header, then the captured value most significant byte first.
  task automatic push_expect(input logic [23:0] val);
    q_h.push_back({1'b0, 8'h54});
    q_h.push_back({1'b0, val[23:16]});
    q_h.push_back({1'b0, val[15:8]});
    q_h.push_back({1'b1, val[7:0]});
    q_n.push_back({1'b0, val[23:16]});
    q_n.push_back({1'b0, val[15:8]});
    q_n.push_back({1'b1, val[7:0]});
    stamp_exp = val;
  endtask

  task automatic flush_model();
    q_h.delete();
    q_n.delete();
    done_pend[0] = 1'b0;
    done_pend[1] = 1'b0;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
  endtask

  task automatic monitor_dut(input int d, input string tag, input logic [7:0] bo,
                             input logic bv, input logic busy, input logic done);
    logic [8:0] e;
    bit         exp_busy;
    bit         exp_done;
    bit         empty;
    empty    = (d == 0) ? (q_h.size() == 0) : (q_n.size() == 0);
    exp_busy = !empty;
    exp_done = done_pend[d];
    done_pend[d] = 1'b0;
    check_output({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    check_output({tag, "_valid"}, {31'd0, bv}, {31'd0, exp_busy});
    check_output({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    if (hold[d]) check_output({tag, "_hold"}, {23'd0, bv, bo}, {23'd0, 1'b1, hold_byte[d]});
    if (bv && BYTE_READY) begin
      if (empty) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_unexpected_byte: got 0x%0h, expected no byte at %0t", tag, bo, $time);
      end else begin
        e = (d == 0) ? q_h.pop_front() : q_n.pop_front();
        check_output({tag, "_byte"}, {24'd0, bo}, {24'd0, e[7:0]});
        if (e[8]) done_pend[d] = 1'b1;
      end
    end
    hold[d]      = bv && !BYTE_READY;
    hold_byte[d] = bo;
  endtask

  // Monitor: every falling clock edge both instances are compared against the model.
  always @(negedge CLK) begin
    if (!NSYSRESET) begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      check_output("ts_update_h", {31'd0, tsu_h}, {31'd0, ts_window});
      check_output("ts_update_n", {31'd0, tsu_n}, {31'd0, ts_window});
      monitor_dut(0, "hdr", bo_h, bv_h, busy_h, done_h);
      monitor_dut(1, "nohdr", bo_n, bv_n, busy_n, done_n);
    end
  end

  task automatic apply_ts_rise(input logic [23:0] val);
    @(posedge CLK);
    #1;
    CLK_10HZ  = 1'b1;
    TIMESTAMP = val;
    repeat (4) @(posedge CLK);
  endtask

  // The load lands on the third edge after CLK_10HZ falls; with_req makes REQ coincide with it.
  task automatic apply_ts_fall(input bit with_req);
    @(posedge CLK);
    #1;
    CLK_10HZ = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    ts_window = 1'b1;
    if (with_req) REQ = 1'b1;
    @(posedge CLK);
    if (with_req) push_expect(model_shadow);
    model_shadow = TIMESTAMP;
    #1;
    ts_window = 1'b0;
    REQ = 1'b0;
    if (with_req) begin
      check_output("stamp_h", {8'd0, stamp_h}, {8'd0, stamp_exp});
      check_output("stamp_n", {8'd0, stamp_n}, {8'd0, stamp_exp});
    end
  endtask

  task automatic apply_req(input bit release_rst);
    @(posedge CLK);
    #1;
    if (release_rst) NSYSRESET = 1'b1;
    REQ = 1'b1;
    @(posedge CLK);
    push_expect(model_shadow);
    #1;
    REQ = 1'b0;
    check_output("stamp_h", {8'd0, stamp_h}, {8'd0, stamp_exp});
    check_output("stamp_n", {8'd0, stamp_n}, {8'd0, stamp_exp});
  endtask

  // Mode 0: random ready, 1: always ready, 2: five stalled cycles per byte.
  // Stray REQs are only raised while both instances are mid-transfer or in FIN.
  task automatic apply_drain(input int mode);
    int cnt;
    int phase;
    cnt   = 0;
    phase = 0;
    while (!model_idle()) begin
      case (mode)
        0: BYTE_READY = ($urandom % 4) != 0;
        1: BYTE_READY = 1'b1;
        default: begin
          BYTE_READY = (phase == 5);
          phase = (phase == 5) ? 0 : phase + 1;
        end
      endcase
      REQ = model_busy(0) && model_busy(1) && (($urandom % 3) == 0);
      @(posedge CLK);
      #1;
      cnt++;
      if (cnt > 300) begin
        checks++;
        errors++;
        $display("[TB] FAIL drain_timeout: got %0d cycles, expected completion within 300", cnt);
        flush_model();
      end
    end
    REQ        = 1'b0;
    BYTE_READY = 1'b0;
    check_output("stamp_hold_h", {8'd0, stamp_h}, {8'd0, stamp_exp});
    check_output("stamp_hold_n", {8'd0, stamp_n}, {8'd0, stamp_exp});
  endtask

  task automatic check_reset_outputs();
    check_output("rst_valid_h", {31'd0, bv_h}, 32'd0);
    check_output("rst_busy_h", {31'd0, busy_h}, 32'd0);
    check_output("rst_done_h", {31'd0, done_h}, 32'd0);
    check_output("rst_byte_h", {24'd0, bo_h}, 32'd0);
    check_output("rst_stamp_h", {8'd0, stamp_h}, 32'd0);
    check_output("rst_tsu_h", {31'd0, tsu_h}, 32'd0);
    check_output("rst_valid_n", {31'd0, bv_n}, 32'd0);
    check_output("rst_busy_n", {31'd0, busy_n}, 32'd0);
    check_output("rst_stamp_n", {8'd0, stamp_n}, 32'd0);
  endtask

  initial begin
    NSYSRESET    = 1'b0;
    CLK_10HZ     = 1'b0;
    TIMESTAMP    = 24'h000000;
    REQ          = 1'b0;
    BYTE_READY   = 1'b0;
    ts_window    = 1'b0;
    model_shadow = 24'h000000;
    stamp_exp    = 24'h000000;
    flush_model();
    #3;
    check_reset_outputs();

    // Request on the first edge after release, before any shadow load: sends zero.
    apply_req(1'b1);
    apply_drain(1);

    apply_ts_rise(24'h123456);
    apply_ts_fall(1'b0);
    apply_req(1'b0);
    apply_drain(1);

    // Backpressure, with a shadow update landing mid-transfer.
    apply_ts_rise(24'hABCDEF);
    apply_ts_fall(1'b0);
    apply_req(1'b0);
    fork
      begin
        apply_ts_rise(24'h111111);
        apply_ts_fall(1'b0);
      end
      apply_drain(2);
    join

    // Request coincident with a shadow load takes the old shadow.
    apply_ts_rise(24'h000010);
    apply_ts_fall(1'b0);
    apply_ts_rise(24'h000011);
    apply_ts_fall(1'b1);
    apply_drain(1);
    apply_req(1'b0);
    apply_drain(1);

    apply_ts_rise(24'hFFFFFF);
    apply_ts_fall(1'b0);
    apply_req(1'b0);
    apply_drain(0);
    apply_ts_rise(24'h000000);
    apply_ts_fall(1'b0);
    apply_req(1'b0);
    apply_drain(0);

    // Reset while the header instance sits in B2 aborts without DONE.
    apply_ts_rise(24'h777777);
    apply_ts_fall(1'b0);
    apply_req(1'b0);
    BYTE_READY = 1'b1;
    @(posedge CLK);
    #1;
    BYTE_READY = 1'b0;
    @(posedge CLK);
    #1;
    NSYSRESET = 1'b0;
    flush_model();
    model_shadow = 24'h000000;
    stamp_exp    = 24'h000000;
    #1;
    check_reset_outputs();
    repeat (3) begin
      @(negedge CLK);
      check_output("rst_no_done_h", {31'd0, done_h}, 32'd0);
      check_output("rst_no_done_n", {31'd0, done_n}, 32'd0);
    end
    apply_req(1'b1);
    apply_drain(1);

    for (int i = 0; i < 10; i++) begin
      logic [23:0] v;
      bit          coincide;
      v        = 24'($urandom);
      coincide = ($urandom % 3) == 0;
      apply_ts_rise(v);
      apply_ts_fall(coincide);
      if (!coincide) apply_req(1'b0);
      apply_drain(0);
    end

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
